// File: rtl/apb_slave_regs.sv
// APB3 completer with a small word-addressed register bank.
// The bank holds a read-only ID, a read-only write counter and RW scratch words.
// Each access inserts a fixed number of wait states.
// Illegal accesses are reported on PSLVERR.
module apb_slave_regs #(
  parameter int unsigned          ADDR_W      = 8,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          NUM_REGS    = 8,
  parameter int unsigned          WAIT_STATES = 1,
  parameter logic [DATA_W-1:0]    ID_VALUE    = 32'hA5B0_0001
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {StIdle, StWait, StReady, StDone} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   wr_count_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic                setup;
  logic [ADDR_W-3:0]   idx;
  logic [IdxW-1:0]     sel;
  logic                err;
  logic [DATA_W-1:0]   rd_val;
  logic                finish;
  logic                commit;

  // Decode the latched request: error classification, read mux, commit strobe.
  always_comb begin
    setup  = PSEL & ~PENABLE;
    idx    = addr_q[ADDR_W-1:2];
    sel    = idx[IdxW-1:0];
    err    = (addr_q[1:0] != 2'b00) || (32'(idx) >= NUM_REGS) || (wr_q && (32'(idx) < 2));
    rd_val = '0;
    if (32'(idx) == 0) begin
      rd_val = ID_VALUE;
    end else if (32'(idx) == 1) begin
      rd_val = wr_count_q;
    end else begin
      rd_val = regs_q[sel];
    end
    // The WAIT->READY edge is the single point where a transfer completes.
    finish = (state_q == StWait) && PSEL && (cnt_q == 4'd0);
    commit = finish && wr_q && !err;
  end

  // Transfer FSM with registered PREADY/PRDATA/PSLVERR (zero whenever not ready).
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // An access phase without a preceding setup is ignored.
          if (setup) begin
            wr_q    <= PWRITE;
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (!PSEL) begin
            state_q <= StIdle;
          end else if (finish) begin
            state_q <= StReady;
            PREADY  <= 1'b1;
            PSLVERR <= err;
            PRDATA  <= (!wr_q && !err) ? rd_val : '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StReady: begin
          state_q <= StDone;
        end
        StDone: begin
          // Wait for the master to leave the access phase so one transfer commits once.
          if (!PENABLE || !PSEL) begin
            if (setup) begin
              wr_q    <= PWRITE;
              addr_q  <= PADDR;
              wdata_q <= PWDATA;
              cnt_q   <= 4'(WAIT_STATES);
              state_q <= StWait;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Register bank: scratch words and the successful-write counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_count_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      wr_count_q  <= wr_count_q + DATA_W'(1);
      regs_q[sel] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs: three instances built with 1, 0 and 3 wait states,
// each on its own bus, compared against a word-level model of the register map.
module tb_apb_slave_regs;

  localparam logic [31:0] IdVal = 32'hA5B0_0001;

  logic        clk;
  logic        rst_n;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [7:0]  paddr   [3];
  logic [31:0] pwdata  [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int checks = 0;
  int errors = 0;

  // Reference model: bank contents and write count per instance.
  logic [31:0] mdl_mem [3][8];
  logic [31:0] mdl_cnt [3];

  apb_slave_regs #(.WAIT_STATES(1)) u_ws1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0])
  );
  apb_slave_regs #(.WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1])
  );
  apb_slave_regs #(.WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mdl_cnt[k] = '0;
      for (int i = 0; i < 8; i++) mdl_mem[k][i] = '0;
    end
  endtask

  // One full transfer as the master drives it, holding PSEL/PENABLE one cycle past PREADY.
  task automatic xfer(input int k, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int   lat;
    logic got;
    @(posedge clk); #1;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = wdata;
    @(posedge clk); #1;
    // Bus changes after setup must not affect the transfer.
    penable[k] = 1'b1; paddr[k] = addr ^ 8'h04; pwdata[k] = ~wdata;
    lat = 0; got = 1'b0; rdata = '0; err = 1'b0;
    while (!got && lat < 40) begin
      if (pready[k]) begin
        got = 1'b1; rdata = prdata[k]; err = pslverr[k];
      end else begin
        chk("quiet_prdata", prdata[k], 32'h0);
        chk("quiet_pslverr", 32'(pslverr[k]), 32'h0);
        @(posedge clk); #1;
        lat++;
      end
    end
    chk("pready_seen", 32'(got), 32'h1);
    chk("latency", 32'(lat), 32'(ws_of(k) + 1));
    @(posedge clk); #1;
    chk("pready_one_cycle", 32'(pready[k]), 32'h0);
    chk("done_prdata", prdata[k], 32'h0);
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  // Transfer plus model prediction and comparison.
  task automatic do_op(input int k, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input string tag);
    int          idx;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [31:0] rdata;
    logic        err;
    idx      = int'(addr >> 2);
    exp_err  = (addr[1:0] != 2'b00) || (idx >= 8) || (wr && idx < 2);
    exp_data = '0;
    if (!wr && !exp_err) exp_data = (idx == 0) ? IdVal : ((idx == 1) ? mdl_cnt[k] : mdl_mem[k][idx]);
    if (wr && !exp_err) begin
      mdl_mem[k][idx] = wdata;
      mdl_cnt[k]      = mdl_cnt[k] + 32'd1;
    end
    xfer(k, wr, addr, wdata, rdata, err);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    if (!wr) chk({tag, "_data"}, rdata, exp_data);
  endtask

  initial begin
    logic [7:0]  a;
    logic        w;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_pready", 32'(pready[k]), 32'h0);
      chk("rst_prdata", prdata[k], 32'h0);
      chk("rst_pslverr", 32'(pslverr[k]), 32'h0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Directed sequence on the one-wait-state instance.
    do_op(0, 1'b0, 8'h00, 32'h0, "read_id");
    do_op(0, 1'b1, 8'h08, 32'hDEAD_BEEF, "wr_scratch");
    do_op(0, 1'b0, 8'h08, 32'h0, "rd_scratch");
    do_op(0, 1'b0, 8'h04, 32'h0, "rd_wrcount");
    chk("wrcount_model_one", mdl_cnt[0], 32'h1);
    do_op(0, 1'b1, 8'h00, 32'h1234, "wr_id");
    do_op(0, 1'b1, 8'h04, 32'h9, "wr_wrcount");
    do_op(0, 1'b0, 8'h00, 32'h0, "reread_id");
    do_op(0, 1'b0, 8'h04, 32'h0, "reread_wrcount");
    do_op(0, 1'b0, 8'h09, 32'h0, "rd_misaligned");
    do_op(0, 1'b0, 8'h20, 32'h0, "rd_oob");
    do_op(0, 1'b1, 8'h1E, 32'h77, "wr_misaligned");
    do_op(0, 1'b1, 8'h1C, 32'h0BAD_F00D, "wr_last");
    do_op(0, 1'b0, 8'h1C, 32'h0, "rd_last");

    // Randomized traffic on all three builds.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        a = 8'($urandom_range(0, 11) * 4);
        if ($urandom_range(0, 7) == 0) a = a | 8'($urandom_range(1, 3));
        w = 1'($urandom_range(0, 1));
        do_op(k, w, a, $urandom, "rand");
      end
      do_op(k, 1'b0, 8'h04, 32'h0, "rand_wrcount");
    end

    // PSEL dropped in WAIT: abort, no completion, no commit.
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h10; pwdata[2] = 32'h7777;
    @(posedge clk); #1;
    psel[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_pready", 32'(pready[2]), 32'h0);
    end
    do_op(2, 1'b0, 8'h10, 32'h0, "abort_rd");
    do_op(2, 1'b0, 8'h04, 32'h0, "abort_wrcount");

    // Reset asserted during WAIT of a write.
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h0C;
    pwdata[2] = 32'h5555_5555;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("midrst_pready", 32'(pready[k]), 32'h0);
      chk("midrst_prdata", prdata[k], 32'h0);
      chk("midrst_pslverr", 32'(pslverr[k]), 32'h0);
    end
    psel[2] = 1'b0; penable[2] = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    do_op(2, 1'b0, 8'h0C, 32'h0, "post_rst_rd");
    do_op(2, 1'b0, 8'h04, 32'h0, "post_rst_wrcount");
    do_op(2, 1'b0, 8'h00, 32'h0, "post_rst_id");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
